// File: rtl/ysyx_23060124_dmem_resp_if.sv
// ============================================================================
//  Module  : ysyx_23060124_dmem_resp_if
//  Brief   : AXI4-Lite-style LSU data port (AR/R, AW/W/B) between master and
//            data-memory responder.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface ysyx_23060124_dmem_resp_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

`default_nettype wire

// File: rtl/ysyx_23060124_dmem_resp.sv
// ============================================================================
//  Module  : ysyx_23060124_dmem_resp
//  Brief   : Data-memory responder for the LSU port: word array, fixed latency,
//            range checking, one outstanding transaction. Optional random extra
//            latency under macro YSYX_23060124_DMEM_RAND_LAT_EN.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ysyx_23060124_dmem_resp #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH_LOG2 = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                    LATENCY    = 2
) (
    input  wire logic                      clk,
    input  wire logic                      i_rst,
    ysyx_23060124_dmem_resp_if.slave       bus
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int CNT_W  = $clog2(LATENCY + 8);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_RD_WAIT = 3'd1;
    localparam logic [2:0] c_RD_RESP = 3'd2;
    localparam logic [2:0] c_WR_WAIT = 3'd3;
    localparam logic [2:0] c_WR_RESP = 3'd4;

    localparam logic [1:0] c_OKAY   = 2'b00;
    localparam logic [1:0] c_SLVERR = 2'b10;

    logic [2:0]            r_state;
    logic [2:0]            w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_lat;
    logic                  w_lat_zero;
    logic                  r_aw_cap;
    logic                  r_w_cap;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]     r_wstrb;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;
    logic [1:0]            r_bresp;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_ar_hs;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_wr_go;
    logic                  w_load;
    logic                  w_rd_enter;
    logic                  w_wr_enter;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [STRB_W-1:0]     w_wr_strb;
    logic [ADDR_WIDTH-1:0] w_rd_off;
    logic [ADDR_WIDTH-1:0] w_wr_off;
    logic                  w_rd_ok;
    logic                  w_wr_ok;
    logic [DEPTH_LOG2-1:0] w_rd_idx;
    logic [DEPTH_LOG2-1:0] w_wr_idx;

    // Handshakes are only possible in IDLE; a pending AR always beats the write.
    assign w_ar_hs = (r_state == c_IDLE) && bus.arvalid;
    assign w_aw_hs = (r_state == c_IDLE) && !r_aw_cap && bus.awvalid;
    assign w_w_hs  = (r_state == c_IDLE) && !r_w_cap && bus.wvalid;
    assign w_wr_go = (r_state == c_IDLE) && !bus.arvalid
                   && (r_aw_cap || w_aw_hs) && (r_w_cap || w_w_hs);
    assign w_load  = w_ar_hs || w_wr_go;

`ifdef YSYX_23060124_DMEM_RAND_LAT_EN
    logic [7:0] r_lfsr;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_lfsr <= 8'hA5;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    assign w_lat = CNT_W'(LATENCY) + CNT_W'(r_lfsr[2:0]);
`else
    assign w_lat = CNT_W'(LATENCY);
`endif
    assign w_lat_zero = (w_lat == '0);

    // With zero latency the response is entered straight from IDLE, so the
    // request fields come from the bus rather than the capture registers.
    assign w_rd_addr = (r_state == c_IDLE) ? bus.araddr : r_araddr;
    assign w_wr_addr = r_aw_cap ? r_awaddr : bus.awaddr;
    assign w_wr_data = r_w_cap  ? r_wdata  : bus.wdata;
    assign w_wr_strb = r_w_cap  ? r_wstrb  : bus.wstrb;

    assign w_rd_off = w_rd_addr - BASE_ADDR;
    assign w_wr_off = w_wr_addr - BASE_ADDR;
    assign w_rd_ok  = (w_rd_addr >= BASE_ADDR) && ((w_rd_off >> (DEPTH_LOG2 + 2)) == '0);
    assign w_wr_ok  = (w_wr_addr >= BASE_ADDR) && ((w_wr_off >> (DEPTH_LOG2 + 2)) == '0);
    assign w_rd_idx = w_rd_off[DEPTH_LOG2+1:2];
    assign w_wr_idx = w_wr_off[DEPTH_LOG2+1:2];

    assign w_rd_enter = (w_next == c_RD_RESP) && (r_state != c_RD_RESP);
    assign w_wr_enter = (w_next == c_WR_RESP) && (r_state != c_WR_RESP);

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_ar_hs) begin
                    w_next = w_lat_zero ? c_RD_RESP : c_RD_WAIT;
                end else if (w_wr_go) begin
                    w_next = w_lat_zero ? c_WR_RESP : c_WR_WAIT;
                end
            end
            c_RD_WAIT: if (r_cnt <= CNT_W'(1)) w_next = c_RD_RESP;
            c_RD_RESP: if (bus.rready)         w_next = c_IDLE;
            c_WR_WAIT: if (r_cnt <= CNT_W'(1)) w_next = c_WR_RESP;
            c_WR_RESP: if (bus.bready)         w_next = c_IDLE;
            default:                           w_next = c_IDLE;
        endcase
    end

    always_comb begin
        bus.arready = 1'b0;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.rvalid  = 1'b0;
        bus.bvalid  = 1'b0;
        case (r_state)
            c_IDLE: begin
                bus.arready = 1'b1;
                bus.awready = !r_aw_cap;
                bus.wready  = !r_w_cap;
            end
            c_RD_RESP: bus.rvalid = 1'b1;
            c_WR_RESP: bus.bvalid = 1'b1;
            default: ;
        endcase
    end

    assign bus.rdata = r_rdata;
    assign bus.rresp = r_rresp;
    assign bus.bresp = r_bresp;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_aw_cap <= 1'b0;
            r_w_cap  <= 1'b0;
            r_araddr <= '0;
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_rdata  <= '0;
            r_rresp  <= c_OKAY;
            r_bresp  <= c_OKAY;
        end else begin
            if (w_load) begin
                r_cnt <= w_lat;
            end else if ((r_state == c_RD_WAIT) || (r_state == c_WR_WAIT)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_ar_hs) begin
                r_araddr <= bus.araddr;
            end
            if (w_aw_hs) begin
                r_aw_cap <= 1'b1;
                r_awaddr <= bus.awaddr;
            end
            if (w_w_hs) begin
                r_w_cap <= 1'b1;
                r_wdata <= bus.wdata;
                r_wstrb <= bus.wstrb;
            end
            if ((r_state == c_WR_RESP) && bus.bready) begin
                r_aw_cap <= 1'b0;
                r_w_cap  <= 1'b0;
            end
            if (w_rd_enter) begin
                r_rdata <= w_rd_ok ? r_mem[w_rd_idx] : '0;
                r_rresp <= w_rd_ok ? c_OKAY : c_SLVERR;
            end
            if (w_wr_enter) begin
                r_bresp <= w_wr_ok ? c_OKAY : c_SLVERR;
            end
        end
    end

    // The reset gate keeps a write racing an asynchronous reset from committing.
    always_ff @(posedge clk) begin
        if (w_wr_enter && w_wr_ok && !i_rst) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (w_wr_strb[b]) begin
                    r_mem[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
                end
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060124_dmem_resp.sv
// ============================================================================
//  Module  : tb_ysyx_23060124_dmem_resp
//  Brief   : Directed self-checking bench for the data-memory responder.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ysyx_23060124_dmem_resp;
    logic clk = 1'b0;
    logic i_rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ysyx_23060124_dmem_resp_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    ysyx_23060124_dmem_resp #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .DEPTH_LOG2 (12),
        .BASE_ADDR  (32'h8000_0000),
        .LATENCY    (2)
    ) u_dut (
        .clk   (clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.araddr  = '0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        bus.awaddr  = '0;
        bus.awvalid = 1'b0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output int lat);
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        lat = 1;
        while (bus.rvalid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        data = bus.rdata;
        resp = bus.rresp;
        tick();
        bus.rready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp, output int lat);
        bus.awaddr  = addr;
        bus.awvalid = 1'b1;
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.wvalid  = 1'b1;
        bus.bready  = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        lat = 1;
        while (bus.bvalid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        resp = bus.bresp;
        tick();
        bus.bready = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        i_rst = 1'b1;
        idle_inputs();
        repeat (3) tick();
        n_vec++;
        if ({bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid} !== 5'b11100) begin
            n_err++;
            $display("FAIL reset_ready_valid: got %b expected %b",
                     {bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid}, 5'b11100);
        end
        n_vec++;
        if ({bus.rdata, bus.rresp, bus.bresp} !== 36'h0) begin
            n_err++;
            $display("FAIL reset_data_resp: got %h expected %h",
                     {bus.rdata, bus.rresp, bus.bresp}, 36'h0);
        end
        i_rst = 1'b0;
        tick();
        bus.araddr  = 32'h8000_0000;
        bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        tick();
        i_rst = 1'b1;
        #1;
        n_vec++;
        if ({bus.rvalid, bus.arready} !== 2'b01) begin
            n_err++;
            $display("FAIL reset_mid_wait: got rvalid,arready=%b expected %b",
                     {bus.rvalid, bus.arready}, 2'b01);
        end
        tick();
        i_rst = 1'b0;
        tick();
        do_read(32'h8000_0000, d, r, lat);
        n_vec++;
        if (r !== 2'b00 || lat !== 3) begin
            n_err++;
            $display("FAIL reset_then_read: got rresp=%b lat=%0d expected rresp=00 lat=3", r, lat);
        end
    endtask

    task automatic test_write_read;
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        do_write(32'h8000_0010, 32'hDEADBEEF, 4'b1111, r, lat);
        n_vec++;
        if (r !== 2'b00 || lat !== 3) begin
            n_err++;
            $display("FAIL write_full: got bresp=%b lat=%0d expected bresp=00 lat=3", r, lat);
        end
        do_read(32'h8000_0010, d, r, lat);
        n_vec++;
        if (d !== 32'hDEADBEEF || r !== 2'b00 || lat !== 3) begin
            n_err++;
            $display("FAIL readback_full: got %h/%b/%0d expected deadbeef/00/3", d, r, lat);
        end
    endtask

    task automatic test_byte_strobe;
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        do_write(32'h8000_0010, 32'h0000_5500, 4'b0010, r, lat);
        do_read(32'h8000_0010, d, r, lat);
        n_vec++;
        if (d !== 32'hDEAD55EF || r !== 2'b00) begin
            n_err++;
            $display("FAIL byte_strobe: got %h/%b expected dead55ef/00", d, r);
        end
        do_write(32'h8000_0010, 32'h1234_5678, 4'b0000, r, lat);
        n_vec++;
        if (r !== 2'b00) begin
            n_err++;
            $display("FAIL zero_strobe_bresp: got %b expected 00", r);
        end
        do_read(32'h8000_0010, d, r, lat);
        n_vec++;
        if (d !== 32'hDEAD55EF) begin
            n_err++;
            $display("FAIL zero_strobe_data: got %h expected dead55ef", d);
        end
    endtask

    task automatic test_contention;
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        logic        bv_seen;
        bus.awaddr  = 32'h8000_0010;
        bus.awvalid = 1'b1;
        bus.wdata   = 32'hCAFE_F00D;
        bus.wstrb   = 4'b1111;
        tick();
        bus.awvalid = 1'b0;
        n_vec++;
        if ({bus.awready, bus.wready} !== 2'b01) begin
            n_err++;
            $display("FAIL split_aw_held: got awready,wready=%b expected 01", {bus.awready, bus.wready});
        end
        tick();
        tick();
        bus.wvalid  = 1'b1;
        bus.araddr  = 32'h8000_0010;
        bus.arvalid = 1'b1;
        tick();
        bus.wvalid  = 1'b0;
        bus.arvalid = 1'b0;
        bv_seen = 1'b0;
        lat = 1;
        while (bus.rvalid !== 1'b1 && lat < 40) begin
            if (bus.bvalid === 1'b1) bv_seen = 1'b1;
            tick();
            lat++;
        end
        n_vec++;
        if (bus.rdata !== 32'hDEAD55EF || lat !== 3 || bv_seen || bus.bvalid !== 1'b0) begin
            n_err++;
            $display("FAIL contention_read_first: got %h lat=%0d bvalid_seen=%b expected dead55ef lat=3 no bvalid",
                     bus.rdata, lat, bv_seen | bus.bvalid);
        end
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        n_vec++;
        if ({bus.arready, bus.awready, bus.wready} !== 3'b100) begin
            n_err++;
            $display("FAIL contention_caps_held: got %b expected 100",
                     {bus.arready, bus.awready, bus.wready});
        end
        bus.bready = 1'b1;
        lat = 0;
        while (bus.bvalid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        n_vec++;
        if (lat !== 3 || bus.bresp !== 2'b00) begin
            n_err++;
            $display("FAIL contention_write_after: got lat=%0d bresp=%b expected lat=3 bresp=00", lat, bus.bresp);
        end
        tick();
        bus.bready = 1'b0;
        do_read(32'h8000_0010, d, r, lat);
        n_vec++;
        if (d !== 32'hCAFEF00D) begin
            n_err++;
            $display("FAIL contention_readback: got %h expected cafef00d", d);
        end
    endtask

    task automatic test_range;
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        do_write(32'h8000_0000, 32'h0BAD_F00D, 4'b1111, r, lat);
        do_read(32'h7FFF_FFFC, d, r, lat);
        n_vec++;
        if (d !== 32'h0 || r !== 2'b10) begin
            n_err++;
            $display("FAIL range_read_low: got %h/%b expected 00000000/10", d, r);
        end
        do_write(32'h8000_4000, 32'h1111_1111, 4'b1111, r, lat);
        n_vec++;
        if (r !== 2'b10) begin
            n_err++;
            $display("FAIL range_write_high: got bresp=%b expected 10", r);
        end
        do_read(32'h8000_0000, d, r, lat);
        n_vec++;
        if (d !== 32'h0BADF00D || r !== 2'b00) begin
            n_err++;
            $display("FAIL range_no_alias: got %h/%b expected 0badf00d/00", d, r);
        end
        do_read(32'h8000_3FFC, d, r, lat);
        n_vec++;
        if (r !== 2'b00) begin
            n_err++;
            $display("FAIL range_last_word: got rresp=%b expected 00", r);
        end
        do_read(32'h8000_4000, d, r, lat);
        n_vec++;
        if (d !== 32'h0 || r !== 2'b10) begin
            n_err++;
            $display("FAIL range_read_high: got %h/%b expected 00000000/10", d, r);
        end
    endtask

    task automatic test_backpressure;
        logic [1:0] r;
        int         lat;
        do_write(32'h8000_0020, 32'h1357_9BDF, 4'b1111, r, lat);
        bus.araddr  = 32'h8000_0020;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b0;
        tick();
        bus.arvalid = 1'b0;
        lat = 1;
        while (bus.rvalid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if ({bus.rvalid, bus.arready} !== 2'b10 || bus.rdata !== 32'h13579BDF || bus.rresp !== 2'b00) begin
                n_err++;
                $display("FAIL backpressure_hold[%0d]: got rvalid,arready=%b rdata=%h rresp=%b expected 10/13579bdf/00",
                         i, {bus.rvalid, bus.arready}, bus.rdata, bus.rresp);
            end
            tick();
        end
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        n_vec++;
        if ({bus.rvalid, bus.arready} !== 2'b01) begin
            n_err++;
            $display("FAIL backpressure_release: got rvalid,arready=%b expected 01", {bus.rvalid, bus.arready});
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        bus.araddr  = 32'h8000_0010;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        lat = 1;
        while (bus.rvalid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        bus.araddr  = 32'h8000_0020;
        bus.arvalid = 1'b1;
        n_vec++;
        if (bus.arready !== 1'b0 || bus.rdata !== 32'hCAFEF00D) begin
            n_err++;
            $display("FAIL b2b_same_cycle: got arready=%b rdata=%h expected 0/cafef00d", bus.arready, bus.rdata);
        end
        tick();
        n_vec++;
        if ({bus.rvalid, bus.arready} !== 2'b01) begin
            n_err++;
            $display("FAIL b2b_next_cycle: got rvalid,arready=%b expected 01", {bus.rvalid, bus.arready});
        end
        tick();
        bus.arvalid = 1'b0;
        lat = 1;
        while (bus.rvalid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        n_vec++;
        if (lat !== 3 || bus.rdata !== 32'h13579BDF) begin
            n_err++;
            $display("FAIL b2b_second_read: got lat=%0d rdata=%h expected 3/13579bdf", lat, bus.rdata);
        end
        tick();
        bus.rready = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1;
        idle_inputs();
        test_reset();
        test_write_read();
        test_byte_strobe();
        test_contention();
        test_range();
        test_backpressure();
        test_back_to_back();
        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule

`default_nettype wire
